// File: rtl/cpu_if_pkg.sv
// Shared definitions for the CPU instruction-load byte link.
// Field widths, transmitter states and the word-to-byte split helpers.
package cpu_if_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 12;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP0,
        ST_STROBE0,
        ST_GAP0,
        ST_SETUP1,
        ST_STROBE1,
        ST_GAP1
    } tx_state_t;

    // First byte carries the opcode in the low nibble and the
    // low nibble of the operand field in the high nibble.
    function automatic logic [BYTE_W-1:0] pack_byte0(
        input logic [OPCODE_W-1:0] opcode,
        input logic [3:0]          instr_lo
    );
        return {instr_lo, opcode};
    endfunction

    // Second byte carries operand bits [11:4].
    function automatic logic [BYTE_W-1:0] pack_byte1(
        input logic [INSTR_W-5:0] instr_hi
    );
        return instr_hi;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/instr_byte_tx_if.sv
// Word handshake and byte-bus signals of the instruction transmitter.
// master: word producer / bus observer; slave: the transmitter.
interface instr_byte_tx_if;
    import cpu_if_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode;
    logic [INSTR_W-1:0]  in_instr;
    logic [BYTE_W-1:0]   tx_data;
    logic                tx_strobe;
    logic                busy;
    logic                done_pulse;

    modport master (
        output in_valid, in_opcode, in_instr,
        input  in_ready, tx_data, tx_strobe, busy, done_pulse
    );

    modport slave (
        input  in_valid, in_opcode, in_instr,
        output in_ready, tx_data, tx_strobe, busy, done_pulse
    );

endinterface

// File: rtl/tx_phase_timer.sv
// Loadable down-counter that times each transmitter phase.
// Ports: clk, rst (sync, high), load, load_val, zero (count == 0).
module tx_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/instr_byte_tx.sv
// Sends one opcode/operand word as two strobed bytes to the CPU loader.
// Ports: clk, rst (sync, high), bus (slave: handshake in, byte bus out).
module instr_byte_tx
    import cpu_if_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            rst,
    instr_byte_tx_if.slave  bus
);

    localparam int MAX_N = max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
    localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

    // The receiver's 2-FF synchronizer needs a 3-cycle pulse and gap.
    if (HOLD_CYCLES < 3 || GAP_CYCLES < 3 || SETUP_CYCLES < 1) begin : g_bad_params
        $error("instr_byte_tx: illegal SETUP/HOLD/GAP_CYCLES");
    end

    tx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [BYTE_W-1:0] byte1_q, byte1_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic              ld;
    logic [CW-1:0]     ld_val;
    logic              tmr_zero;

    tx_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .zero     (tmr_zero)
    );

    // Outputs are derived from the next state so every pad is a flop.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        byte1_d   = byte1_q;
        done_d    = 1'b0;
        ld        = 1'b0;
        ld_val    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d   = ST_SETUP0;
                    ld        = 1'b1;
                    ld_val    = SETUP_LD;
                    tx_data_d = pack_byte0(bus.in_opcode, bus.in_instr[3:0]);
                    byte1_d   = pack_byte1(bus.in_instr[11:4]);
                end
            end
            ST_SETUP0: begin
                if (tmr_zero) begin
                    state_d = ST_STROBE0;
                    ld      = 1'b1;
                    ld_val  = HOLD_LD;
                end
            end
            ST_STROBE0: begin
                if (tmr_zero) begin
                    state_d = ST_GAP0;
                    ld      = 1'b1;
                    ld_val  = GAP_LD;
                end
            end
            ST_GAP0: begin
                if (tmr_zero) begin
                    state_d   = ST_SETUP1;
                    ld        = 1'b1;
                    ld_val    = SETUP_LD;
                    tx_data_d = byte1_q;
                end
            end
            ST_SETUP1: begin
                if (tmr_zero) begin
                    state_d = ST_STROBE1;
                    ld      = 1'b1;
                    ld_val  = HOLD_LD;
                end
            end
            ST_STROBE1: begin
                if (tmr_zero) begin
                    state_d = ST_GAP1;
                    ld      = 1'b1;
                    ld_val  = GAP_LD;
                end
            end
            ST_GAP1: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        strobe_d = (state_d == ST_STROBE0) || (state_d == ST_STROBE1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            byte1_q   <= '0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            byte1_q   <= byte1_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_strobe  = strobe_q;
    assign bus.done_pulse = done_q;

endmodule
